// File: rtl/chain_sched_pkg.sv
// Shared types and constants for the chain_sched pipeline scheduler.
package chain_sched_pkg;

  localparam int CNT_W      = 16;
  localparam int ID_MAX_W   = 4;
  localparam int DATA_MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } state_t;

  typedef struct packed {
    logic                  valid;
    logic [ID_MAX_W-1:0]   id;
    logic [DATA_MAX_W-1:0] data;
  } stage_t;

endpackage

// File: rtl/chain_sched_rr_pick.sv
// Round-robin picker: one-hot grant for the first set request at or above ptr, wrapping.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  grant
);

  logic [PW:0] idx;
  logic        found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, ptr} + (PW+1)'(k);
      if (idx >= (PW+1)'(N)) idx = idx - (PW+1)'(N);
      if (en && !found && req[idx[PW-1:0]]) begin
        grant[idx[PW-1:0]] = 1'b1;
        found              = 1'b1;
      end
    end
  end

endmodule

// File: rtl/chain_sched.sv
// Round-robin scheduler feeding an LAT-deep stallable register chain.
// Optional per-requester saturating grant counters under CHAIN_SCHED_STATS_EN.
module chain_sched
  import chain_sched_pkg::*;
#(
  parameter  int NREQ = 4,
  parameter  int DW   = 8,
  parameter  int LAT  = 5,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic               resp_valid,
  output logic [IW-1:0]      resp_id,
  output logic [DW-1:0]      resp_data,
  input  logic               resp_ready,
  output logic               busy
`ifdef CHAIN_SCHED_STATS_EN
  ,
  output logic [NREQ*CNT_W-1:0] grant_cnt
`endif
);

  logic            adv;
  logic            xfer;
  logic [NREQ-1:0] grant;
  logic [IW-1:0]   gid;
  logic [DW-1:0]   gdata;
  logic [IW-1:0]   rr_ptr;
  state_t          state;
  state_t          state_next;
  logic [LAT-1:0]  vld;
  logic [LAT-1:0]  vld_next;
  logic [IW-1:0]   id_q   [LAT];
  logic [DW-1:0]   data_q [LAT];

  assign adv = !(vld[LAT-1] && !resp_ready);

  rr_pick #(.N(NREQ), .PW(IW)) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .en    (adv),
    .grant (grant)
  );

  assign req_ready = grant;
  assign xfer      = |grant;

  always_comb begin
    gid = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) gid = IW'(i);
    end
    gdata = req_data[int'(gid)*DW +: DW];
  end

  // Next contents of the valid chain; an empty cycle shifts in a bubble.
  always_comb begin
    vld_next = vld;
    if (adv) begin
      vld_next[0] = xfer;
      for (int k = 1; k < LAT; k++) vld_next[k] = vld[k-1];
    end
  end

  always_comb begin
    if (!(|vld_next))                          state_next = IDLE;
    else if (vld_next[LAT-1] && !resp_ready)   state_next = STALL;
    else                                       state_next = RUN;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld    <= '0;
      rr_ptr <= '0;
      state  <= IDLE;
    end else begin
      vld   <= vld_next;
      state <= state_next;
      if (xfer) rr_ptr <= (int'(gid) == NREQ-1) ? '0 : gid + 1'b1;
    end
  end

  // Payload side of the chain carries no reset; its valid bit guards it.
  always_ff @(posedge clk) begin
    if (adv) begin
      id_q[0]   <= gid;
      data_q[0] <= gdata;
      for (int k = 1; k < LAT; k++) begin
        id_q[k]   <= id_q[k-1];
        data_q[k] <= data_q[k-1];
      end
    end
  end

  assign resp_valid = vld[LAT-1];
  assign resp_id    = id_q[LAT-1];
  assign resp_data  = data_q[LAT-1];
  assign busy       = (state != IDLE);

`ifdef CHAIN_SCHED_STATS_EN
  logic [CNT_W-1:0] cnt [NREQ];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (grant[i] && cnt[i] != {CNT_W{1'b1}}) cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NREQ; i++) grant_cnt[i*CNT_W +: CNT_W] = cnt[i];
  end
`endif

endmodule

// File: tb/tb_chain_sched.sv
// Self-checking bench for chain_sched (default parameters); build with
// CHAIN_SCHED_STATS_EN defined to include the grant counter scenario.
module tb_chain_sched;
  import chain_sched_pkg::*;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int LAT  = 5;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ*DW-1:0] req_data = '0;
  logic [NREQ-1:0]    req_ready;
  logic               resp_valid;
  logic [1:0]         resp_id;
  logic [DW-1:0]      resp_data;
  logic               resp_ready = 1'b1;
  logic               busy;
`ifdef CHAIN_SCHED_STATS_EN
  logic [NREQ*CNT_W-1:0] grant_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [9:0] sbq [$];
  int         m_ptr = 0;
  logic [3:0] mon_eg;
  logic       mon_adv;
  logic [9:0] mon_exp;

  chain_sched #(.NREQ(NREQ), .DW(DW), .LAT(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .resp_ready (resp_ready),
    .busy       (busy)
`ifdef CHAIN_SCHED_STATS_EN
    ,
    .grant_cnt  (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] pick(input logic [3:0] rv, input int p);
    logic [3:0] g;
    int j;
    g = '0;
    for (int k = 0; k < 4; k++) begin
      j = (p + k) % 4;
      if (g == 4'b0 && rv[j]) g[j] = 1'b1;
    end
    return g;
  endfunction

  // Scoreboard: expected grant from a pointer model, results queued at acceptance.
  always @(negedge clk) begin
    if (rst) begin
      sbq.delete();
      m_ptr = 0;
    end else begin
      mon_adv = !(resp_valid && !resp_ready);
      mon_eg  = mon_adv ? pick(req_valid, m_ptr) : 4'b0;
      n_checks++;
      if (req_ready !== mon_eg) begin
        n_fail++;
        $display("FAIL grant: req_ready=%b expected=%b", req_ready, mon_eg);
      end
      if (resp_valid && resp_ready) begin
        n_checks++;
        if (sbq.size() == 0) begin
          n_fail++;
          $display("FAIL spurious_result: id=%0d data=%h with nothing outstanding", resp_id, resp_data);
        end else begin
          mon_exp = sbq.pop_front();
          if ({resp_id, resp_data} !== mon_exp) begin
            n_fail++;
            $display("FAIL result_order: got id=%0d data=%h expected id=%0d data=%h",
                     resp_id, resp_data, mon_exp[9:8], mon_exp[7:0]);
          end
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (mon_eg[i]) begin
          sbq.push_back({2'(i), req_data[i*DW +: DW]});
          m_ptr = (i + 1) % 4;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    req_valid  = '0;
    resp_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    req_valid  = '0;
    resp_ready = 1'b1;
    step();
    @(negedge clk);
    n_checks++;
    if (resp_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: resp_valid=%b busy=%b expected 0 0", resp_valid, busy);
    end
    n_checks++;
    if (dut.rr_ptr !== 2'd0 || dut.state !== IDLE) begin
      n_fail++;
      $display("FAIL reset_state: rr_ptr=%0d state=%0d expected 0 IDLE", dut.rr_ptr, dut.state);
    end
    step();
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 4'b0010;
    req_data[1*DW +: DW] = 8'hA5;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 0) begin
        n_checks++;
        if (req_ready !== 4'b0010) begin
          n_fail++;
          $display("FAIL single_grant: req_ready=%b expected 0010", req_ready);
        end
      end
      n_checks++;
      if (resp_valid !== (c == 5)) begin
        n_fail++;
        $display("FAIL single_latency c=%0d: resp_valid=%b expected %b", c, resp_valid, c == 5);
      end
      if (c == 5) begin
        n_checks++;
        if (resp_id !== 2'd1 || resp_data !== 8'hA5) begin
          n_fail++;
          $display("FAIL single_payload: id=%0d data=%h expected 1 a5", resp_id, resp_data);
        end
      end
      n_checks++;
      if (busy !== (c >= 1 && c <= 5)) begin
        n_fail++;
        $display("FAIL single_busy c=%0d: busy=%b expected %b", c, busy, c >= 1 && c <= 5);
      end
      step();
      if (c == 0) req_valid = '0;
    end
  endtask

  task automatic test_all_four();
    logic [7:0] ed;
    do_reset();
    for (int c = 0; c < 18; c++) begin
      if (c < 12) begin
        req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) req_data[i*DW +: DW] = 8'(c * 16 + i);
      end else begin
        req_valid = '0;
      end
      @(negedge clk);
      if (c < 12) begin
        n_checks++;
        if (req_ready !== 4'(1 << (c % 4))) begin
          n_fail++;
          $display("FAIL rr_order c=%0d: req_ready=%b expected %b", c, req_ready, 4'(1 << (c % 4)));
        end
      end
      if (c >= 5 && c < 17) begin
        ed = 8'((c - 5) * 16 + (c - 5) % 4);
        n_checks++;
        if (resp_valid !== 1'b1 || resp_id !== 2'((c - 5) % 4) || resp_data !== ed) begin
          n_fail++;
          $display("FAIL rr_result c=%0d: valid=%b id=%0d data=%h expected 1 %0d %h",
                   c, resp_valid, resp_id, resp_data, (c - 5) % 4, ed);
        end
      end else begin
        n_checks++;
        if (resp_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL rr_idle c=%0d: resp_valid=%b expected 0", c, resp_valid);
        end
      end
      step();
    end
  endtask

  task automatic test_stall();
    logic [9:0] hold;
    int         emitted;
    emitted = 0;
    hold    = '0;
    do_reset();
    for (int c = 0; c < 17; c++) begin
      req_valid  = (c < 11) ? 4'b1111 : 4'b0000;
      resp_ready = !(c >= 8 && c <= 10);
      for (int i = 0; i < 4; i++) req_data[i*DW +: DW] = 8'(8'h80 + c * 4 + i);
      @(negedge clk);
      if (resp_valid && resp_ready) emitted++;
      if (c == 8) hold = {resp_id, resp_data};
      if (c >= 8 && c <= 10) begin
        n_checks++;
        if (req_ready !== 4'b0 || resp_valid !== 1'b1 || {resp_id, resp_data} !== hold) begin
          n_fail++;
          $display("FAIL stall_hold c=%0d: req_ready=%b valid=%b out=%h expected 0000 1 %h",
                   c, req_ready, resp_valid, {resp_id, resp_data}, hold);
        end
      end
      if (c >= 9 && c <= 10) begin
        n_checks++;
        if (dut.state !== STALL) begin
          n_fail++;
          $display("FAIL stall_state c=%0d: state=%0d expected STALL", c, dut.state);
        end
      end
      if (c >= 11) begin
        n_checks++;
        if (resp_valid !== (c <= 15)) begin
          n_fail++;
          $display("FAIL stall_drain c=%0d: resp_valid=%b expected %b", c, resp_valid, c <= 15);
        end
      end
      step();
    end
    n_checks++;
    if (emitted != 8 || sbq.size() != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_count: emitted=%0d left=%0d busy=%b expected 8 0 0", emitted, sbq.size(), busy);
    end
  endtask

  task automatic test_sparse();
    do_reset();
    req_data[0*DW +: DW] = 8'h3C;
    req_data[3*DW +: DW] = 8'hC3;
    for (int c = 0; c < 12; c++) begin
      req_valid = (c == 0) ? 4'b0001 : (c == 3) ? 4'b1000 : 4'b0000;
      @(negedge clk);
      n_checks++;
      if (resp_valid !== (c == 5 || c == 8)) begin
        n_fail++;
        $display("FAIL sparse_valid c=%0d: resp_valid=%b expected %b", c, resp_valid, c == 5 || c == 8);
      end
      if (c == 5 || c == 8) begin
        n_checks++;
        if ({resp_id, resp_data} !== ((c == 5) ? {2'd0, 8'h3C} : {2'd3, 8'hC3})) begin
          n_fail++;
          $display("FAIL sparse_payload c=%0d: id=%0d data=%h", c, resp_id, resp_data);
        end
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    int emitted;
    emitted = 0;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      req_valid = 4'b1111;
      for (int i = 0; i < 4; i++) req_data[i*DW +: DW] = 8'(8'h40 + c * 4 + i);
      step();
    end
    req_valid = '0;
    rst       = 1'b1;
    #1;
    n_checks++;
    if (resp_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: resp_valid=%b busy=%b expected 0 0", resp_valid, busy);
    end
    step();
    rst = 1'b0;
    req_valid = 4'b1111;
    req_data[0*DW +: DW] = 8'h77;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_priority: req_ready=%b expected 0001", req_ready);
    end
    step();
    req_valid = '0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (resp_valid) emitted++;
      step();
    end
    n_checks++;
    if (emitted != 1) begin
      n_fail++;
      $display("FAIL reset_flush: results after reset=%0d expected 1", emitted);
    end
  endtask

`ifdef CHAIN_SCHED_STATS_EN
  task automatic test_stats();
    do_reset();
    req_valid = 4'b0100;
    req_data[2*DW +: DW] = 8'h5A;
    for (int c = 0; c < 70000; c++) step();
    req_valid = '0;
    @(negedge clk);
    n_checks++;
    if (grant_cnt[2*CNT_W +: CNT_W] !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL stats_sat: cnt2=%h expected ffff", grant_cnt[2*CNT_W +: CNT_W]);
    end
    n_checks++;
    if (grant_cnt[0 +: 2*CNT_W] !== '0 || grant_cnt[3*CNT_W +: CNT_W] !== '0) begin
      n_fail++;
      $display("FAIL stats_others: cnt=%h expected zeros outside requester 2", grant_cnt);
    end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_stall();
    test_sparse();
    test_reset_mid();
`ifdef CHAIN_SCHED_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
